uart_tx_controller: RTL and testbench



---
 rtl/uart_tx_controller.sv | 154 +++++++++++++++
 tb/tb_uart_tx_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - FIFO-buffered UART transmitter; optional parity via UART_TX_PARITY_EN
module uart_tx_controller #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUDRATE    = 9600,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ODD_PARITY  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_empty,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          TX
);
    localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic                 baud_last;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    assign wr_ready   = (fifo_count != (AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = wr_valid && wr_ready;
    assign head       = mem[rd_ptr];
    assign baud_last  = (baud_cnt == BW'(DIV - 1));
    assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));
    assign tx_busy    = (state != IDLE);

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`else
    logic unused_odd_parity;
    assign unused_odd_parity = (ODD_PARITY != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= wr_data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Data bits are shifted out of bit 0, so TX always carries the next LSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            TX         <= 1'b1;
            tx_done    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Registered one cycle early so the pulse lands on STOP's final cycle.
            tx_done <= (state == STOP) && (baud_cnt == BW'(DIV - 2));
            if (state == IDLE) begin
                baud_cnt <= '0;
                TX       <= 1'b1;
                if (pop) begin
                    shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= (^head) ^ (ODD_PARITY != 0);
`endif
                    state      <= START;
                    TX         <= 1'b0;
                end
            end else if (!baud_last) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        TX      <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TX    <= parity_bit;
`else
                            state <= STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            TX        <= shift_reg[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        TX    <= 1'b1;
                    end
`endif
                    STOP: begin
                        if (pop) begin
                            shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= (^head) ^ (ODD_PARITY != 0);
`endif
                            state      <= START;
                            TX         <= 1'b0;
                        end else begin
                            state <= IDLE;
                            TX    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        TX    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - directed vector bench for uart_tx_controller
module tb_uart_tx_controller;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 2 + 8 + P;
    localparam int F  = NB * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    uart_tx_controller #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUDRATE   (100_000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16),
        .ODD_PARITY (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .fifo_count(fifo_count),
        .fifo_empty(fifo_empty),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .TX        (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       e_tx;
        logic [4:0] e_count;
        logic       e_ready;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((tx_busy || !fifo_empty) && n < 5000) begin
            tick();
            n++;
        end
        chk({name, " idle timeout"}, 32'(n >= 5000), 0);
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic check_frame(input int start, input logic [7:0] exp, input string name);
        logic [NB-1:0] bits;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = exp[i];
        if (P == 1) bits[9] = ^exp;
        bits[NB-1] = 1'b1;
        wait_until(start);
        if (cyc == start) chk({name, " start edge"}, 32'(tx), 0);
        for (int k = 0; k < NB; k++) begin
            wait_until(start + k * DIV + 5);
            chk($sformatf("%s bit%0d", name, k), 32'(tx), 32'(bits[k]));
        end
        wait_until(start + F - 2);
        chk({name, " done early"}, 32'(tx_done), 0);
        tick();
        chk({name, " done"}, 32'(tx_done), 1);
    endtask

    vec_t vt [6];
    int   n0;
    int   bad;

    initial begin
        vt[0] = '{1'b1, 1'b1, 8'h33, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'h44, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 8'h55, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};

        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            reset    = vt[i].rst;
            wr_valid = vt[i].valid;
            wr_data  = vt[i].data;
            tick();
            if (i == 3) n0 = cyc;
            chk($sformatf("vec%0d tx", i),    32'(tx),         32'(vt[i].e_tx));
            chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vt[i].e_count));
            chk($sformatf("vec%0d ready", i), 32'(wr_ready),   32'(vt[i].e_ready));
            chk($sformatf("vec%0d busy", i),  32'(tx_busy),    32'(vt[i].e_busy));
            chk($sformatf("vec%0d done", i),  32'(tx_done),    32'(vt[i].e_done));
        end
        wr_valid = 1'b0;

        check_frame(n0 + 1, 8'hA5, "single");
        chk("single busy at end", 32'(tx_busy), 1);
        tick();
        chk("single busy after", 32'(tx_busy), 0);
        chk("single tx idle", 32'(tx), 1);
        chk("single done cleared", 32'(tx_done), 0);

`ifdef UART_TX_PARITY_EN
        wait_idle("pre parity");
        push(8'h07);
        n0 = cyc;
        check_frame(n0 + 1, 8'h07, "parity");
`endif

        wait_idle("pre full");
        for (int i = 0; i <= 16; i++) begin
            push(8'(i));
            if (i == 0) n0 = cyc;
        end
        chk("full count", 32'(fifo_count), 16);
        chk("full ready", 32'(wr_ready), 0);
        push(8'h11);
        chk("full refused count", 32'(fifo_count), 16);
        for (int k = 0; k < 17; k++) begin
            check_frame(n0 + 1 + k * F, 8'(k), $sformatf("full%0d", k));
        end
        tick();
        chk("full drained busy", 32'(tx_busy), 0);
        chk("full drained count", 32'(fifo_count), 0);

        wait_idle("pre b2b");
        push(8'h55);
        n0 = cyc;
        push(8'hAA);
        check_frame(n0 + 1, 8'h55, "b2b first");
        check_frame(n0 + 1 + F, 8'hAA, "b2b second");

        wait_idle("pre reset");
        push(8'hFF);
        n0 = cyc;
        push(8'h12);
        push(8'h34);
        wait_until(n0 + 1 + 4 * DIV + 5);
        chk("mid bit3", 32'(tx), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid reset tx", 32'(tx), 1);
        chk("mid reset count", 32'(fifo_count), 0);
        chk("mid reset busy", 32'(tx_busy), 0);
        chk("mid reset done", 32'(tx_done), 0);
        bad = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        chk("line idle after reset", 32'(bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
